rr_mux_arb: RTL and testbench
=============================

# rr_mux_arb

Parametrised N-channel, W-bit round-robin arbitrated multiplexer with a valid/ready handshake on every input and a registered output stage. It generalises the fixed 4:1 select-driven mux. Select is no longer an external input: an internal rotating-priority pointer chooses among requesting channels, and the chosen beat is held in an output register until the consumer accepts it. It sits between several producer pipelines and one shared consumer datapath.

## Interface
- N, default 4, number of input channels (N ≥ 1).
- W, default 4, data width in bits (W ≥ 1).
- CW (localparam), $clog2(N) with a minimum of 1, width of out_chan.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies [i*W +: W].
- in_valid  input  N  bit i: channel i presents a beat.
- in_ready  output  N  bit i: channel i's beat is accepted this cycle (one-hot or zero).
- out_data  output  W  registered output beat.
- out_chan  output  CW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_chan hold a valid beat.
- out_ready  input  1  consumer accepts the beat this cycle.

## Operation
- State: output register (out_data, out_chan, out_valid) and priority pointer ptr (CW bits, range 0..N-1).
- free = !out_valid | out_ready. The register can take a new beat this cycle.
- Grant g is the first index with in_valid set, searching circularly from ptr (ptr, ptr+1, …, N-1, 0, …, ptr-1).
- in_ready[g] = free & in_valid[g] & !reset. All other in_ready bits are 0. in_ready is combinational from in_valid, ptr, out_valid and out_ready.
- A transfer occurs on a clock edge when free and any in_valid is set. Registered effects of a transfer:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - ptr <= (g+1) mod N
- Free but no in_valid set: out_valid <= 0. ptr, out_data and out_chan keep their values.
- Not free (out_valid & !out_ready): all state holds. in_ready = 0.
- Reset (sampled at the edge): out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0. Any held beat is dropped. in_ready is forced to 0 while reset is high.
- Fairness: a channel that keeps in_valid asserted is granted within N consecutive transfers.
- Producers must hold in_data/in_valid stable until in_ready is set. The block does not check this.
- N = 1: ptr and out_chan are always 0. The block behaves as a one-entry pipeline register.

## Timing
- Latency: a beat accepted at edge k is visible on out_* immediately after edge k. It stays there until the first edge with out_ready = 1.
- Throughput: one beat per cycle when out_ready is held high. A new beat is accepted on the same edge that the current one is consumed.
- While out_valid & !out_ready, out_data and out_chan are stable cycle to cycle.
- Reset values after the first reset edge: out_valid 0, out_data 0, out_chan 0, ptr 0.
- Simultaneous consume and accept on one edge: the new beat replaces the old one, and out_valid stays 1.
- Pointer wrap: a grant of channel N-1 sets ptr to 0.

## Test plan
All scenarios use N=4, W=4.
- Reset: reset=1 for 2 cycles with in_valid=1111 and out_ready=1 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0.
- Single requester: only in_valid[2]=1, ch2 data 0xA, out_ready=1 -> in_ready=0100 in cycle 0; after the edge out_valid=1, out_data=0xA, out_chan=2, ptr=3.
- Round robin: in_valid=1111 held, data ch0..ch3 = 0x1,0x2,0x3,0x4, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1, no idle cycles.
- Backpressure: after the first beat (ch0, 0x1), hold out_ready=0 for 3 cycles -> out_data=0x1, out_chan=0, in_ready=0000 throughout, ptr stays 1. Raise out_ready -> the next beat is ch1 (0x2).
- Pointer skip and wrap: ptr=1, only ch0 and ch3 valid (0x5, 0x9) -> ch3 granted first (out_data=0x9), ptr wraps to 0, then ch0 (out_data=0x5).
- Reset mid-operation: out_valid=1 holding ch2's beat with out_ready=0, pulse reset for 1 cycle -> out_valid=0 next cycle. With in_valid=1111 afterwards, the first grant is ch0.

Source files
------------

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel round-robin arbitrated mux with valid/ready inputs and a registered output
module rr_mux_arb #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);
    logic [W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_chan_q, out_chan_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] g;
    logic          found;
    logic          free;
    logic          xfer;
    int            idx;

    // circular search for the first requester starting at the priority pointer
    always_comb begin
        g = ptr_q;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && in_valid[idx]) begin
                g = CW'(idx);
                found = 1'b1;
            end
        end
    end

    // handshake, next output beat and pointer advance past the granted channel
    always_comb begin
        free = !out_valid_q || out_ready;
        xfer = free && found;
        in_ready = (xfer && !reset) ? (N'(1) << g) : '0;
        out_valid_d = free ? found : out_valid_q;
        out_data_d = xfer ? in_data[g*W +: W] : out_data_q;
        out_chan_d = xfer ? g : out_chan_q;
        ptr_d = xfer ? ((g == CW'(N - 1)) ? '0 : g + CW'(1)) : ptr_q;
    end

    // output register and pointer; reset drops any held beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed and randomized checks of rr_mux_arb against a behavioural model
module tb_rr_mux_arb;
    localparam int N = 4;
    localparam int W = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;
    int mv = 0, md = 0, mc = 0, mp = 0;

    always #5 clk = ~clk;

    rr_mux_arb #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic int grant();
        for (int k = 0; k < N; k++)
            if (in_valid[(mp + k) % N]) return (mp + k) % N;
        return -1;
    endfunction

    function automatic int exp_ready();
        int gg = grant();
        if (reset || (mv != 0 && !out_ready) || gg < 0) return 0;
        return 1 << gg;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        in_data = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic tick();
        int gg;
        #1;
        chk("in_ready_model", 32'(in_ready), exp_ready());
        @(posedge clk);
        gg = grant();
        if (reset) begin
            mv = 0; md = 0; mc = 0; mp = 0;
        end else if (mv == 0 || out_ready) begin
            if (gg >= 0) begin
                mv = 1;
                md = int'(in_data[gg*W +: W]);
                mc = gg;
                mp = (gg + 1) % N;
            end else begin
                mv = 0;
            end
        end
        #1;
        chk("out_valid_model", 32'(out_valid), mv);
        chk("out_data_model", 32'(out_data), md);
        chk("out_chan_model", 32'(out_chan), mc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        set_data(1, 2, 3, 4);
        #1 chk("reset_in_ready0", 32'(in_ready), 0);
        tick();
        #1 chk("reset_in_ready1", 32'(in_ready), 0);
        tick();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_chan", 32'(out_chan), 0);

        reset = 1'b0;
        in_valid = 4'b0100;
        set_data(0, 0, 'hA, 0);
        #1 chk("single_in_ready", 32'(in_ready), 'b0100);
        tick();
        chk("single_out_valid", 32'(out_valid), 1);
        chk("single_out_data", 32'(out_data), 'hA);
        chk("single_out_chan", 32'(out_chan), 2);
        in_valid = 4'b1111;
        set_data(1, 2, 3, 4);
        #1 chk("single_ptr3_grant", 32'(in_ready), 'b1000);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_out_valid", 32'(out_valid), 1);
            chk("rr_out_chan", 32'(out_chan), i % 4);
            chk("rr_out_data", 32'(out_data), (i % 4) + 1);
        end

        do_reset();
        tick();
        chk("bp_first_chan", 32'(out_chan), 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", 32'(in_ready), 0);
            tick();
            chk("bp_hold_data", 32'(out_data), 1);
            chk("bp_hold_chan", 32'(out_chan), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 'b0010);
        tick();
        chk("bp_next_chan", 32'(out_chan), 1);
        chk("bp_next_data", 32'(out_data), 2);

        do_reset();
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b1001;
        set_data(5, 0, 0, 9);
        tick();
        chk("wrap_first_chan", 32'(out_chan), 3);
        chk("wrap_first_data", 32'(out_data), 9);
        tick();
        chk("wrap_second_chan", 32'(out_chan), 0);
        chk("wrap_second_data", 32'(out_data), 5);

        do_reset();
        in_valid = 4'b0100;
        set_data(0, 0, 7, 0);
        out_ready = 1'b0;
        tick();
        tick();
        chk("mid_held_chan", 32'(out_chan), 2);
        do_reset();
        chk("mid_reset_valid", 32'(out_valid), 0);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        set_data(1, 2, 3, 4);
        #1 chk("mid_first_ready", 32'(in_ready), 'b0001);
        tick();
        chk("mid_first_chan", 32'(out_chan), 0);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            in_valid = N'($urandom);
            in_data = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
